// File: rtl/encoder8to3_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : encoder8to3_drain_if
// Description : Handshake bundle for encoder8to3_drain. Carries the request
//               vector side (in_valid/in_req/in_ready) and the beat side
//               (out_valid/out_ready/out_idx/out_onehot/out_last).
//               master : producer of vectors / consumer of beats (testbench)
//               slave  : the encoder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface encoder8to3_drain_if;
  logic       in_valid;
  logic [7:0] in_req;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic       out_last;

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_last
  );

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_last
  );
endinterface
`default_nettype wire

// File: rtl/encoder8to3_drain.sv
`default_nettype none
// ============================================================================
// Module      : encoder8to3_drain
// Description : Sequential 8-to-3 encoder. Accepts an 8-bit request vector
//               and emits the index of every set bit, one per beat, in fixed
//               priority order, together with its one-hot decode.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               bus        - encoder8to3_drain_if.slave handshake bundle
//               vec_count  - popcount of last accepted vector
//                            (only when ENC_POPCOUNT_EN is defined)
// Parameters  : PRIORITY_HIGH - 0: ascending (bit 0 first), 1: descending
// Macro       : ENC_POPCOUNT_EN - enables the vec_count output
// Revision    : 1.0 - initial release
// ============================================================================
module encoder8to3_drain #(
  parameter int PRIORITY_HIGH = 0
) (
  input  wire                       clk,
  input  wire                       rst,
  encoder8to3_drain_if.slave        bus
`ifdef ENC_POPCOUNT_EN
  ,
  output logic [3:0]                vec_count
`endif
);

  logic [7:0] pending_q,    pending_d;
  logic [2:0] out_idx_q,    out_idx_d;
  logic [7:0] out_onehot_q, out_onehot_d;
  logic       out_valid_q,  out_valid_d;
  logic       out_last_q,   out_last_d;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_beat;
  logic [7:0] w_src;
  logic [2:0] w_sel;
  logic [7:0] w_sel_onehot;
  logic [7:0] w_rest;

  // Same selector serves the first beat (from in_req) and later beats
  // (from pending), so ordering cannot diverge between the two paths.
  function automatic logic [2:0] pick_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIORITY_HIGH != 0) begin
      for (int i = 0; i < 8; i++)
        if (vec[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // A new vector may load while the final beat of the previous one is
  // being taken, giving back-to-back vectors with no bubble.
  assign w_in_ready = !out_valid_q | (bus.out_ready & out_last_q);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_beat     = out_valid_q & bus.out_ready;

  always_comb begin
    w_src        = w_accept ? bus.in_req : pending_q;
    w_sel        = pick_idx(w_src);
    w_sel_onehot = 8'd1 << w_sel;
    w_rest       = w_src & ~w_sel_onehot;

    pending_d    = pending_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;

    if (w_accept || (w_beat && pending_q != 8'd0)) begin
      if (w_src != 8'd0) begin
        out_idx_d    = w_sel;
        out_onehot_d = w_sel_onehot;
        out_valid_d  = 1'b1;
        pending_d    = w_rest;
        out_last_d   = (w_rest == 8'd0);
      end else begin
        // Zero vector accepted: consumed without producing a beat.
        out_onehot_d = 8'd0;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        pending_d    = 8'd0;
      end
    end else if (w_beat) begin
      out_onehot_d = 8'd0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 8'd0;
      out_idx_q    <= 3'd0;
      out_onehot_q <= 8'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_onehot = out_onehot_q;
  assign bus.out_last   = out_last_q;

`ifdef ENC_POPCOUNT_EN
  logic [3:0] vec_count_q, vec_count_d;

  always_comb begin
    vec_count_d = vec_count_q;
    if (w_accept) begin
      vec_count_d = 4'd0;
      for (int i = 0; i < 8; i++)
        vec_count_d = vec_count_d + {3'd0, bus.in_req[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vec_count_q <= 4'd0;
    else     vec_count_q <= vec_count_d;
  end

  assign vec_count = vec_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_encoder8to3_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder8to3_drain
// Description : Self-checking bench for encoder8to3_drain. Two instances
//               (ascending and descending priority) share one stimulus
//               stream; a queue-based reference model of expected beats
//               checks both every cycle.
// Macro       : ENC_POPCOUNT_EN - also checks vec_count
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder8to3_drain;

  logic clk;
  logic rst;

  encoder8to3_drain_if ia ();
  encoder8to3_drain_if ib ();

`ifdef ENC_POPCOUNT_EN
  logic [3:0] vc_a, vc_b;
`endif

  encoder8to3_drain #(.PRIORITY_HIGH(0)) u_asc (
    .clk(clk), .rst(rst), .bus(ia.slave)
`ifdef ENC_POPCOUNT_EN
    , .vec_count(vc_a)
`endif
  );

  encoder8to3_drain #(.PRIORITY_HIGH(1)) u_desc (
    .clk(clk), .rst(rst), .bus(ib.slave)
`ifdef ENC_POPCOUNT_EN
    , .vec_count(vc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Entry: [6] last, [5:3] ascending index, [2:0] descending index.
  logic [6:0] mq[$];
  int         vec_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] req, input logic rdy);
    ia.in_valid = v;  ia.in_req = req;  ia.out_ready = rdy;
    ib.in_valid = v;  ib.in_req = req;  ib.out_ready = rdy;
  endtask

  task automatic push_vec(input logic [7:0] v);
    int bits[$];
    for (int i = 0; i < 8; i++)
      if (v[i]) bits.push_back(i);
    for (int k = 0; k < bits.size(); k++)
      mq.push_back({(k == bits.size() - 1), 3'(bits[k]), 3'(bits[bits.size() - 1 - k])});
  endtask

  // Compare both DUTs with the model at the falling edge, then advance the
  // model across the next rising edge.
  task automatic step();
    logic       exp_valid, exp_rdy;
    logic [2:0] ea, eb;
    @(negedge clk);
    exp_valid = (mq.size() > 0);
    exp_rdy   = (mq.size() == 0) || (ia.out_ready && mq.size() == 1);
    check("a_valid", 32'(ia.out_valid), 32'(exp_valid));
    check("b_valid", 32'(ib.out_valid), 32'(exp_valid));
    check("a_in_ready", 32'(ia.in_ready), 32'(exp_rdy));
    check("b_in_ready", 32'(ib.in_ready), 32'(exp_rdy));
    if (exp_valid) begin
      ea = mq[0][5:3];
      eb = mq[0][2:0];
      check("a_idx", 32'(ia.out_idx), 32'(ea));
      check("b_idx", 32'(ib.out_idx), 32'(eb));
      check("a_onehot", 32'(ia.out_onehot), 32'(1) << ea);
      check("b_onehot", 32'(ib.out_onehot), 32'(1) << eb);
      check("a_last", 32'(ia.out_last), 32'(mq[0][6]));
      check("b_last", 32'(ib.out_last), 32'(mq[0][6]));
    end else begin
      check("a_onehot_idle", 32'(ia.out_onehot), 32'd0);
      check("b_onehot_idle", 32'(ib.out_onehot), 32'd0);
    end
`ifdef ENC_POPCOUNT_EN
    check("a_vec_count", 32'(vc_a), 32'(vec_exp));
    check("b_vec_count", 32'(vc_b), 32'(vec_exp));
`endif
    if (mq.size() > 0 && ia.out_ready) void'(mq.pop_front());
    if (ia.in_valid && exp_rdy) begin
      push_vec(ia.in_req);
      vec_exp = $countones(ia.in_req);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         asc_exp[4];
    int         desc_exp[4];
    logic [7:0] req;

    asc_exp  = '{0, 2, 5, 7};
    desc_exp = '{7, 5, 2, 0};

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("rst_valid", 32'(ia.out_valid), 32'd0);
    check("rst_idx", 32'(ia.out_idx), 32'd0);
    check("rst_onehot", 32'(ia.out_onehot), 32'd0);
    check("rst_last", 32'(ia.out_last), 32'd0);
    check("rst_in_ready", 32'(ia.in_ready), 32'd1);
`ifdef ENC_POPCOUNT_EN
    check("rst_vec_count", 32'(vc_a), 32'd0);
`endif
    rst = 1'b0;
    step();

    // 8'b1010_0101 drained at full rate in both priority orders.
    drive(1'b1, 8'hA5, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("tp_asc_idx", 32'(ia.out_idx), 32'(asc_exp[k]));
      check("tp_desc_idx", 32'(ib.out_idx), 32'(desc_exp[k]));
      check("tp_asc_last", 32'(ia.out_last), 32'(k == 3));
      check("tp_desc_last", 32'(ib.out_last), 32'(k == 3));
      step();
    end
    check("tp_drained", 32'(ia.out_valid), 32'd0);

    // Backpressure on the second beat of 8'hFF.
    drive(1'b1, 8'hFF, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp_idx", 32'(ia.out_idx), 32'd1);
      check("bp_onehot", 32'(ia.out_onehot), 32'h02);
      check("bp_in_ready", 32'(ia.in_ready), 32'd0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("bp_resume_idx", 32'(ia.out_idx), 32'd2);
    repeat (8) step();

    // Back-to-back: 8'h80 offered in the last-beat handshake of 8'h03.
    drive(1'b1, 8'h03, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("b2b_last_prev", 32'(ia.out_last), 32'd1);
    drive(1'b1, 8'h80, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    check("b2b_valid", 32'(ia.out_valid), 32'd1);
    check("b2b_idx", 32'(ia.out_idx), 32'd7);
    check("b2b_last", 32'(ia.out_last), 32'd1);
    repeat (2) step();

    // Zero vector, then full vector for the popcount extremes.
    drive(1'b1, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    check("zero_valid", 32'(ia.out_valid), 32'd0);
    check("zero_in_ready", 32'(ia.in_ready), 32'd1);
`ifdef ENC_POPCOUNT_EN
    check("zero_vec_count", 32'(vc_a), 32'd0);
`endif
    drive(1'b1, 8'hFF, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
`ifdef ENC_POPCOUNT_EN
    check("ff_vec_count", 32'(vc_a), 32'd8);
`endif
    repeat (9) step();

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, 8'hFF, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(ia.out_valid), 32'd0);
    check("arst_onehot", 32'(ia.out_onehot), 32'd0);
    check("arst_in_ready", 32'(ia.in_ready), 32'd1);
    mq.delete();
    vec_exp = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'(1) << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      drive(1'($urandom_range(0, 1)), req, ($urandom_range(0, 3) != 0));
      step();
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder8to3_drain.md
# encoder8to3_drain

Sequential 8-to-3 encoder, the inverse of the combinational 3-to-8 decoder in the combinational library. It accepts an 8-bit request vector through a valid/ready handshake and emits the index of every set bit, one index per beat, in fixed priority order. Each beat also carries the decoded one-hot form of the index. It serves as the index-serialising front end for interrupt, grant and bit-mask consumers that need one encoded index at a time.

## Interface
Parameters:
- PRIORITY_HIGH, default 0: 0 = ascending index order (bit 0 first); 1 = descending order (bit 7 first).

Ports:
- clk  input  1  Single clock for the block; all state updates on the rising edge.
- rst  input  1  Reset, asynchronous and active-high.
- in_valid  input  1  Request vector present.
- in_req  input  8  Request vector; bit i set = emit index i.
- in_ready  output  1  Block can accept a vector this cycle.
- out_valid  output  1  out_idx/out_onehot hold a valid beat.
- out_ready  input  1  Consumer takes the beat.
- out_idx  output  3  Encoded index of the current beat.
- out_onehot  output  8  out_idx decoded to one-hot: bit out_idx set.
- out_last  output  1  Current beat is the final index of its vector.
- vec_count  output  4  Present only with ENC_POPCOUNT_EN.

## Operation
- State: pending[7:0] holds the bits not yet emitted. The output register holds out_idx, out_onehot, out_valid and out_last.
- in_ready = !out_valid | (out_ready & out_last). This is combinational and allows back-to-back vectors.
- Accept (in_valid & in_ready) of a nonzero in_req:
  - The first-priority bit p of in_req is selected.
  - out_idx <= p, out_onehot <= 1<<p, out_valid <= 1.
  - pending <= in_req with bit p cleared.
  - out_last <= (that cleared result == 0).
- Accept of in_req == 0: the vector is consumed and no beat is produced. If no beat is in flight, out_valid is 0 on the next cycle.
- Beat handshake (out_valid & out_ready) without a same-cycle accept:
  - If pending != 0, the next priority bit is selected from pending and registered as above, and it is cleared from pending.
  - Else out_valid <= 0 and out_last <= 0.
- A same-cycle handshake on the last beat and accept of a new vector: the new vector wins and loads as above, so there is no bubble.
- When out_valid & !out_ready, all outputs and pending hold stable.
- The number of beats per vector equals popcount(in_req), from 0 to 8.
- The priority select is a pure function of PRIORITY_HIGH and is the same for the first beat and for subsequent beats.

## Timing
- Reset values: out_valid 0, out_idx 3'd0, out_onehot 8'h00, out_last 0, pending 8'h00, vec_count 4'd0. in_ready reads 1 while in reset.
- Reset asserted mid-drain clears all state immediately. Remaining indices are discarded and none are emitted after release.
- Latency: a vector accepted at rising edge k produces its first beat with out_valid high after edge k.
- Throughput: one beat per cycle while out_ready = 1. A vector with n set bits drains in n cycles.
- out_onehot always equals the decode of out_idx when out_valid = 1, and is 0 when out_valid = 0.

## Configuration
- ENC_POPCOUNT_EN defined:
  - The vec_count[3:0] output port exists.
  - vec_count is loaded with popcount(in_req), from 0 to 8, on every accept (including zero vectors) and holds until the next accept. Reset value is 0.
- ENC_POPCOUNT_EN undefined: the port and its counting logic are absent. All other behaviour is identical.

## Test plan
- PRIORITY_HIGH=0, out_ready=1, in_req=8'b1010_0101:
  - out_idx 0,2,5,7 on four consecutive cycles; out_onehot 01,04,20,80.
  - out_last only on idx 7; in_ready high in that cycle.
- PRIORITY_HIGH=1, same vector -> out_idx 7,5,2,0; out_last on idx 0.
- Backpressure on 8'hFF: drop out_ready for 3 cycles on the 2nd beat -> out_idx=1 and out_onehot=02 held stable, in_ready=0; the drain resumes with idx 2 after release.
- Back-to-back: present 8'h80 with in_valid in the out_last handshake cycle of 8'h03 -> accepted; next beat idx 7 with out_last=1, no idle cycle.
- Zero vector and popcount:
  - in_req=8'h00 accepted -> out_valid stays 0, in_ready stays 1.
  - With ENC_POPCOUNT_EN: vec_count=0; then 8'hFF -> vec_count=8.
- Reset mid-drain: assert rst after 3 beats of 8'hFF -> out_valid=0, out_onehot=00 asynchronously; after release in_ready=1 and no further beats.
